// File: rtl/conv2_act_sched.sv
// conv2_act_sched: drains the PE accumulator stream for conv layer 2,
// applies requantise + clamped ReLU, packs four 8-bit activations per
// 32-bit little-endian word and writes them to the output buffer.
module conv2_act_sched #(
   parameter int TOTAL  = 1152,
   parameter int ADDR_W = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   output logic                     busy,
   output logic                     done,
   input  logic                     acc_valid,
   output logic                     acc_ready,
   input  logic signed [19:0]       acc_data,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [31:0]              wr_data,
   output logic [3:0]               wr_strb
);

   localparam int CNT_W = $clog2(TOTAL + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q,   ptr_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [1:0]        lane_q,  lane_d;
   logic [31:0]       pack_q,  pack_d;
   logic [3:0]        strb_q,  strb_d;
   logic              wvld_q,  wvld_d;

   logic signed [19:0] s1, s2;
   logic [7:0]         act;
   logic               acc_hs, wr_hs, last_el, all_in;

   assign acc_ready = (state_q == S_RUN) & ~wvld_q;
   assign acc_hs    = acc_valid & acc_ready;
   assign wr_hs     = wvld_q & wr_ready;
   // the element being accepted now is the final one of the frame
   assign last_el   = (cnt_q + CNT_W'(1)) == CNT_W'(TOTAL);
   assign all_in    = cnt_q == CNT_W'(TOTAL);

   assign busy     = (state_q == S_RUN) | (state_q == S_DRAIN);
   assign done     = (state_q == S_DONE);
   assign wr_valid = wvld_q;
   assign wr_addr  = ptr_q;
   assign wr_data  = pack_q;
   assign wr_strb  = strb_q;

   // requantise (>>2, -128, >>5) then clamp to [0,127]
   always_comb begin
      s1  = (acc_data >>> 2) - 20'sd128;
      s2  = s1 >>> 5;
      act = s2[7:0];
      if (s2 > 20'sd127)
         act = 8'd127;
      else if (s2[19])
         act = 8'd0;
   end

   // next-state: frame sequencing, lane packing and word write handshake
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      lane_d  = lane_q;
      pack_d  = pack_q;
      strb_d  = strb_q;
      wvld_d  = wvld_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               ptr_d   = base_addr;
               cnt_d   = '0;
               lane_d  = '0;
               pack_d  = '0;
               strb_d  = '0;
               wvld_d  = 1'b0;
            end
         end
         S_RUN, S_DRAIN: begin
            if (wr_hs) begin
               // word accepted: clear the pack and move to the next address
               wvld_d = 1'b0;
               pack_d = '0;
               strb_d = '0;
               lane_d = '0;
               ptr_d  = ptr_q + ADDR_W'(1);
               if (all_in)
                  state_d = S_DONE;
            end else if (acc_hs) begin
               for (int k = 0; k < 4; k++) begin
                  if (lane_q == 2'(k)) begin
                     pack_d[8*k +: 8] = act;
                     strb_d[k]        = 1'b1;
                  end
               end
               lane_d = lane_q + 2'd1;
               cnt_d  = cnt_q + CNT_W'(1);
               if ((lane_q == 2'd3) || last_el)
                  wvld_d = 1'b1;
               // final element: hold busy until its word is written
               if (last_el)
                  state_d = S_DRAIN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         lane_q  <= '0;
         pack_q  <= '0;
         strb_q  <= '0;
         wvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         lane_q  <= lane_d;
         pack_q  <= pack_d;
         strb_q  <= strb_d;
         wvld_q  <= wvld_d;
      end
   end

endmodule
